// File: rtl/blood_type_encoder.sv
// Serial blood-type entry: captures anti-A, anti-B and anti-D results into a 3-bit code.
// Optional double-entry confirmation is enabled with `define BLOOD_CONFIRM_EN.
//
// state  | meaning
// IDLE   | waiting for start
// GET_A  | waiting for anti-A result (code bit 2)
// GET_B  | waiting for anti-B result (code bit 1)
// GET_D  | waiting for anti-D result (code bit 0)
// GET_A2 | confirm anti-A entry (BLOOD_CONFIRM_EN only)
// GET_B2 | confirm anti-B entry (BLOOD_CONFIRM_EN only)
// GET_D2 | confirm anti-D entry (BLOOD_CONFIRM_EN only)
// HOLD   | code presented, waiting for typeReady
// ERR    | timeout or confirm mismatch, waiting for start
module blood_type_encoder #(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int CNT_W          = 10
) (
  input  logic       clk,
  input  logic       rstN,
  input  logic       start,
  input  logic       testValid,
  input  logic       testBit,
  input  logic       typeReady,
  output logic [2:0] bloodType,
  output logic       typeValid,
  output logic       busy,
  output logic       error
);

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    GET_A = 4'd1,
    GET_B = 4'd2,
    GET_D = 4'd3,
    HOLD  = 4'd4,
    ERR   = 4'd5
`ifdef BLOOD_CONFIRM_EN
    ,
    GET_A2 = 4'd6,
    GET_B2 = 4'd7,
    GET_D2 = 4'd8
`endif
  } stateT;

  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(TIMEOUT_CYCLES - 1);

  stateT            state, stateNext;
  logic [CNT_W-1:0] cnt, cntNext;
  logic [2:0]       cap, capNext;
  logic [2:0]       typeNext;
  logic             inGet;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state     <= IDLE;
      cnt       <= '0;
      cap       <= '0;
      bloodType <= '0;
    end else begin
      state     <= stateNext;
      cnt       <= cntNext;
      cap       <= capNext;
      bloodType <= typeNext;
    end
  end

  always_comb begin
    inGet = 1'b0;
    case (state)
      GET_A, GET_B, GET_D: inGet = 1'b1;
`ifdef BLOOD_CONFIRM_EN
      GET_A2, GET_B2, GET_D2: inGet = 1'b1;
`endif
      default: inGet = 1'b0;
    endcase
  end

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    capNext   = cap;
    typeNext  = bloodType;

    if (state == IDLE || state == ERR) begin
      if (start) begin
        stateNext = GET_A;
        capNext   = '0;
        cntNext   = '0;
      end
    end else if (state == HOLD) begin
      if (typeReady) stateNext = IDLE;
    end else if (inGet) begin
      if (start) begin
        stateNext = GET_A;
        capNext   = '0;
        cntNext   = '0;
      end else if (testValid) begin
        cntNext = '0;
        case (state)
`ifdef BLOOD_CONFIRM_EN
          GET_A: begin
            capNext[2] = testBit;
            stateNext  = GET_A2;
          end
          GET_A2: stateNext = (testBit == cap[2]) ? GET_B : ERR;
          GET_B: begin
            capNext[1] = testBit;
            stateNext  = GET_B2;
          end
          GET_B2: stateNext = (testBit == cap[1]) ? GET_D : ERR;
          GET_D: begin
            capNext[0] = testBit;
            stateNext  = GET_D2;
          end
          GET_D2: begin
            if (testBit == cap[0]) begin
              typeNext  = cap;
              stateNext = HOLD;
            end else begin
              stateNext = ERR;
            end
          end
`else
          GET_A: begin
            capNext[2] = testBit;
            stateNext  = GET_B;
          end
          GET_B: begin
            capNext[1] = testBit;
            stateNext  = GET_D;
          end
          GET_D: begin
            capNext[0] = testBit;
            // Code is loaded on the same edge as the HOLD transition.
            typeNext   = {cap[2:1], testBit};
            stateNext  = HOLD;
          end
`endif
          default: stateNext = state;
        endcase
      end else if (cnt == CNT_TERM) begin
        stateNext = ERR;
        cntNext   = '0;
      end else begin
        cntNext = cnt + CNT_W'(1);
      end
    end
  end

  assign busy      = inGet;
  assign typeValid = (state == HOLD);
  assign error     = (state == ERR);

endmodule

// File: tb/tb_blood_type_encoder.sv
// Directed bench for blood_type_encoder; table of full entries plus corner sequences.
// Confirmation sequences run when BLOOD_CONFIRM_EN is defined.
module tb_blood_type_encoder;

  logic       clk;
  logic       rstN;
  logic       start;
  logic       testValid;
  logic       testBit;
  logic       typeReady;
  logic [2:0] bloodType;
  logic       typeValid;
  logic       busy;
  logic       error;

  int errors = 0;
  int checks = 0;

  blood_type_encoder #(.TIMEOUT_CYCLES(1000), .CNT_W(10)) dut (
    .clk(clk),
    .rstN(rstN),
    .start(start),
    .testValid(testValid),
    .testBit(testBit),
    .typeReady(typeReady),
    .bloodType(bloodType),
    .typeValid(typeValid),
    .busy(busy),
    .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       a;
    logic       b;
    logic       d;
    logic [2:0] expType;
  } vecT;

  vecT vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulseStart();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic strobe(input logic b);
    testValid = 1'b1;
    testBit   = b;
    step();
    testValid = 1'b0;
  endtask

  task automatic enterBit(input logic b);
    strobe(b);
`ifdef BLOOD_CONFIRM_EN
    strobe(b);
`endif
  endtask

  initial begin
    rstN = 1'b1; start = 1'b0; testValid = 1'b0; testBit = 1'b0; typeReady = 1'b0;
    vecs[0] = '{1'b0, 1'b0, 1'b0, 3'b000};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 3'b001};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 3'b010};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 3'b011};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 3'b100};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 3'b101};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 3'b110};
    vecs[7] = '{1'b1, 1'b1, 1'b1, 3'b111};

    #2 rstN = 1'b0;
    step(); step();
    check("rst_type", 32'(bloodType), 32'h0);
    check("rst_valid", 32'(typeValid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_error", 32'(error), 32'h0);
    #3 rstN = 1'b1;
    step();

    // IDLE ignores testValid
    strobe(1'b1);
    check("idle_ign_busy", 32'(busy), 32'h0);
    check("idle_ign_valid", 32'(typeValid), 32'h0);

    // Table of full entries
    for (int i = 0; i < 8; i++) begin
      pulseStart();
      check($sformatf("v%0d_busy", i), 32'(busy), 32'h1);
      enterBit(vecs[i].a);
      enterBit(vecs[i].b);
      enterBit(vecs[i].d);
      check($sformatf("v%0d_valid", i), 32'(typeValid), 32'h1);
      check($sformatf("v%0d_type", i), 32'(bloodType), 32'(vecs[i].expType));
      check($sformatf("v%0d_busy_hold", i), 32'(busy), 32'h0);
      typeReady = 1'b1;
      step();
      typeReady = 1'b0;
      check($sformatf("v%0d_valid_off", i), 32'(typeValid), 32'h0);
      check($sformatf("v%0d_type_kept", i), 32'(bloodType), 32'(vecs[i].expType));
    end

    // 101 held for 10 cycles, then handshake
    pulseStart();
    enterBit(1'b1);
    enterBit(1'b0);
    check("hold_valid_rise", 32'(typeValid), 32'h0);
    enterBit(1'b1);
    for (int k = 0; k < 10; k++) begin
      check("hold_type", 32'(bloodType), 32'h5);
      check("hold_valid", 32'(typeValid), 32'h1);
      step();
    end
    typeReady = 1'b1;
    step();
    typeReady = 1'b0;
    check("hold_release", 32'(typeValid), 32'h0);
    check("hold_release_type", 32'(bloodType), 32'h5);

    // Timeout: error exactly 1000 cycles after the last capture
    pulseStart();
    strobe(1'b1);
    repeat (999) step();
    check("to_pre_error", 32'(error), 32'h0);
    check("to_pre_busy", 32'(busy), 32'h1);
    step();
    check("to_error", 32'(error), 32'h1);
    check("to_busy", 32'(busy), 32'h0);
    check("to_valid", 32'(typeValid), 32'h0);
    check("to_type_kept", 32'(bloodType), 32'h5);
    strobe(1'b1);
    check("err_ign_tv", 32'(error), 32'h1);
    pulseStart();
    check("err_clear", 32'(error), 32'h0);
    check("err_restart_busy", 32'(busy), 32'h1);
    enterBit(1'b0);
    enterBit(1'b1);
    enterBit(1'b0);
    check("after_err_type", 32'(bloodType), 32'h2);
    typeReady = 1'b1;
    step();
    typeReady = 1'b0;

    // Restart mid-entry discards the first capture
    pulseStart();
    strobe(1'b1);
    pulseStart();
    enterBit(1'b0);
    enterBit(1'b0);
    enterBit(1'b0);
    check("restart_type", 32'(bloodType), 32'h0);
    check("restart_valid", 32'(typeValid), 32'h1);
    typeReady = 1'b1;
    step();
    typeReady = 1'b0;

    // HOLD ignores start/testValid
    pulseStart();
    enterBit(1'b0);
    enterBit(1'b1);
    enterBit(1'b1);
    for (int k = 0; k < 4; k++) begin
      start = k[0];
      testValid = 1'b1;
      testBit = ~k[0];
      step();
      check("hold_ign_type", 32'(bloodType), 32'h3);
      check("hold_ign_valid", 32'(typeValid), 32'h1);
    end
    start = 1'b0; testValid = 1'b0;
    typeReady = 1'b1;
    step();
    check("hold_ign_exit", 32'(typeValid), 32'h0);
    check("hold_ign_busy", 32'(busy), 32'h0);

    // typeReady high throughout: one-cycle typeValid
    pulseStart();
    enterBit(1'b1);
    enterBit(1'b1);
    enterBit(1'b1);
    check("rdy_hi_valid", 32'(typeValid), 32'h1);
    check("rdy_hi_type", 32'(bloodType), 32'h7);
    step();
    check("rdy_hi_valid_off", 32'(typeValid), 32'h0);
    typeReady = 1'b0;

    // Asynchronous reset mid-entry (bloodType currently 111)
    pulseStart();
    strobe(1'b1);
    check("arst_pre_busy", 32'(busy), 32'h1);
    #2 rstN = 1'b0;
    #1;
    check("arst_type", 32'(bloodType), 32'h0);
    check("arst_busy", 32'(busy), 32'h0);
    check("arst_valid", 32'(typeValid), 32'h0);
    check("arst_error", 32'(error), 32'h0);
    #1 rstN = 1'b1;
    step();
    strobe(1'b1);
    check("arst_idle", 32'(busy), 32'h0);

`ifdef BLOOD_CONFIRM_EN
    pulseStart();
    strobe(1'b1); strobe(1'b1);
    strobe(1'b1); strobe(1'b1);
    strobe(1'b0);
    check("cf_pre_valid", 32'(typeValid), 32'h0);
    strobe(1'b0);
    check("cf_type", 32'(bloodType), 32'h6);
    check("cf_valid", 32'(typeValid), 32'h1);
    typeReady = 1'b1;
    step();
    typeReady = 1'b0;
    pulseStart();
    strobe(1'b1);
    check("cf_mis_pre", 32'(error), 32'h0);
    strobe(1'b0);
    check("cf_mis_error", 32'(error), 32'h1);
    check("cf_mis_busy", 32'(busy), 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
